// File: rtl/count_seg7_pkg.sv
// count_seg7_pkg: shared types and constants for the two-digit scanned
// 7-segment display stage (scan state, blank pattern, digit segment table).
package count_seg7_pkg;

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } scan_state_e;

    // All segments dark on a common-anode, active-low display.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9; index 0 is the LSB slice.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/count_seg7_scan_decode.sv
// seg7_decode: combinational digit-to-segment decoder, active-low outputs.
// Codes 10..15 are not decimal digits and leave the digit dark.
module seg7_decode
    import count_seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // Table lookup for decimal digits, blank otherwise.
    always_comb begin
        seg_o = SEG_OFF;
        if (digit_i <= 4'd9) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

// File: rtl/count_seg7_scan.sv
// count_seg7_scan: samples the upstream 4-bit down counter, shows it as two
// decimal digits on a time-multiplexed common-anode display, and flags
// 0 -> 15 wrap-around with a one-cycle pulse plus a toggling tens decimal point.
// Build option: define COUNT_SEG7_SCAN_BLANK_EN to blank a leading-zero tens digit.
//
// state | meaning
// ------+-------------------------------------------------------------
// ONES  | ones digit lit (an=10); leaving it starts the tens half-frame
// TENS  | tens digit lit (an=01); leaving it is the frame boundary,
//       | where the displayed value is re-latched
module count_seg7_scan
    import count_seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = $clog2(SCAN_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dp,
    output logic       wrap
);

    logic [3:0]       q_cap_q;
    logic             wrap_q;
    logic             wrap_d;
    logic             wrap_flag_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             tick;
    scan_state_e      state_q;
    scan_state_e      state_d;
    logic             frame_end;
    logic [3:0]       disp_q;
    logic             tens_bit;
    logic [3:0]       ones_val;
    logic [3:0]       digit_sel;
    logic [6:0]       digit_seg;
    logic [6:0]       seg_d;
    logic [1:0]       an_d;
    logic             dp_d;
    logic [6:0]       seg_q;
    logic [1:0]       an_q;
    logic             dp_q;

    assign wrap_d = (q_cap_q == 4'h0) && (q == 4'hF);
    assign tick   = (div_cnt_q == DIV_W'(SCAN_DIV - 1));

    // Capture the counter, detect wrap and keep the wrap-parity flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_cap_q     <= 4'hF;
            wrap_q      <= 1'b0;
            wrap_flag_q <= 1'b0;
        end else begin
            q_cap_q     <= q;
            wrap_q      <= wrap_d;
            wrap_flag_q <= wrap_flag_q ^ wrap_d;
        end
    end

    // Per-digit dwell prescaler.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Scan state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ONES;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan next-state: alternate digits on every prescaler tick.
    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        case (state_q)
            ONES: begin
                if (tick) begin
                    state_d = TENS;
                end
            end
            TENS: begin
                if (tick) begin
                    state_d   = ONES;
                    frame_end = 1'b1;
                end
            end
            default: state_d = ONES;
        endcase
    end

    // Latch the displayed value only between frames so a frame never tears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_q <= 4'hF;
        end else if (frame_end) begin
            disp_q <= q_cap_q;
        end
    end

    // Split 0..15 into tens (0/1) and ones; subtraction cannot underflow.
    always_comb begin
        tens_bit = (disp_q >= 4'd10);
        ones_val = disp_q - (tens_bit ? 4'd10 : 4'd0);
        if (state_q == TENS) begin
            digit_sel = {3'b000, tens_bit};
        end else begin
            digit_sel = ones_val;
        end
    end

    seg7_decode u_decode (
        .digit_i (digit_sel),
        .seg_o   (digit_seg)
    );

    // Next values for the display drivers from the current digit.
    always_comb begin
        seg_d = digit_seg;
        an_d  = 2'b10;
        dp_d  = 1'b1;
        if (state_q == TENS) begin
            an_d = 2'b01;
            dp_d = ~wrap_flag_q;
`ifdef COUNT_SEG7_SCAN_BLANK_EN
            if (!tens_bit) begin
                seg_d = SEG_OFF;
            end
`endif
        end
    end

    // Registered display drivers; dark while in reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_q <= SEG_OFF;
            an_q  <= 2'b11;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = dp_q;
    assign wrap = wrap_q;

endmodule

// File: doc/count_seg7_scan.md
# count_seg7_scan

Display stage directly downstream of the 4-bit down counter: samples its count output every cycle, converts it to two decimal digits (00–15) and drives a time-multiplexed, common-anode, two-digit 7-segment display. Also flags counter wrap-around (0 → 15) as a one-cycle pulse and a toggling decimal point, so wrap events are visible on the board.

## Interface
- SCAN_DIV, default 100000: clk cycles each digit is lit. Legal range is ≥ 2.
- DIV_W, default $clog2(SCAN_DIV): prescaler width.
- clk  input  1  rising-edge clock, same domain as the counter.
- rst  input  1  reset, synchronous, active-low.
- q  input  4  count value from the upstream down counter.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  2  digit anodes, active-low. an[0] drives the ones digit; an[1] drives the tens digit.
- dp  output  1  decimal point, active-low, shown on the tens digit only.
- wrap  output  1  one-cycle pulse on a detected 0 → 15 transition of q.

## Operation
- Input capture: q_r <= q every cycle. q_r resets to 4'hF, which matches the upstream reset value.
- Wrap detect: wrap <= (q_r == 4'h0) && (q == 4'hF).
  - A wrap pulse also toggles wrap_flag, which resets to 0.
  - The transition 15 → 14 does not raise wrap. Holding at 0 does not raise wrap.
- Prescaler: div_cnt counts from 0 to SCAN_DIV-1 and then returns to 0. tick = (div_cnt == SCAN_DIV-1).
- FSM, two states, resetting to ONES:
  - ONES → TENS on tick.
  - TENS → ONES on tick. This transition is the frame boundary.
- Display latch: disp_r <= q_r only at the frame boundary. Mid-frame changes to q never tear the displayed value. disp_r resets to 4'hF.
- Arithmetic:
  - tens = (disp_r >= 10).
  - ones = disp_r − (tens ? 10 : 0), computed as 4-bit unsigned with no overflow possible.
- Output register: seg, an and dp are registered from the current state, disp_r and wrap_flag.
  - In ONES: an=2'b10, seg=decode(ones), dp=1.
  - In TENS: an=2'b01, seg=decode(tens), dp=~wrap_flag.
- Decode table (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
- Reset mid-operation: every register returns to its reset value on the next edge, and scanning restarts in ONES with div_cnt=0.

## Timing
- Output values during reset and on the first cycle after release: seg=7'h7F, an=2'b11, dp=1, wrap=0.
- From reset release, the first tick occurs at cycle SCAN_DIV-1.
- The output register lags the FSM/disp_r by one cycle. an changes exactly one cycle after the edge on which the state toggles.
- Latency from q to seg:
  - 1 cycle (q_r), plus
  - a wait of up to 2·SCAN_DIV cycles for the frame boundary, plus
  - 1 cycle (output register).
- wrap is asserted on the cycle after the edge that presents q=15 following q_r=0. Its latency is 1 cycle.
- Simultaneous wrap and frame boundary: disp_r latches the pre-wrap q_r (0), and wrap_flag toggles in the same cycle.

## Configuration
- Macro COUNT_SEG7_SCAN_BLANK_EN.
- Defined: leading-zero blanking. In TENS with tens=0, seg=7'h7F and dp still follows wrap_flag.
- Undefined: the tens digit always shows 0 or 1.

## Structure
- Package count_seg7_pkg holds:
  - the state enum {ONES, TENS};
  - SEG_OFF = 7'h7F;
  - the 10-entry segment constant table.
- Sub-module seg7_decode: purely combinational, 4-bit digit to 7-bit active-low segments. Values 10–15 decode to SEG_OFF.
- The top level contains q_r, wrap logic, prescaler, FSM, disp_r and the output register.

## Test plan
All directed tests use SCAN_DIV=4.
- Reset: rst=0 for 3 cycles with q=5 → seg=7F, an=11, dp=1, wrap=0. The first an toggle occurs 4 cycles after release.
- Value 7: hold q=7 for 3 frames → an=10/seg=78 alternating with an=01/seg=40. With the macro defined, the tens digit shows seg=7F. Each digit is held for 4 cycles.
- Value 12: hold q=12 → an=10/seg=24 and an=01/seg=79.
- Wrap: drive q sequence 1, 0, 15, 14 → one wrap pulse, 1 cycle after 15 is applied. dp=0 on tens frames afterwards. A second 0 → 15 restores dp=1. Holding 0,0 gives no wrap.
- Tear-free: change q from 3 to 9 during a ONES digit → seg keeps showing 3 until the frame boundary, then shows 9 (seg=10).
- Mid-scan reset: assert rst during TENS → next edge gives an=11, seg=7F, dp=1, wrap_flag cleared. Scanning resumes in ONES.
